// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: request/grant for addresses, rvalid for returned words.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // A request is accepted in a cycle where imem_req and imem_gnt are both high;
    // req/addr hold until then, and each grant returns exactly one rvalid, in order.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// parks a returned word in a skid buffer on stall and drops wrong-path data on flush.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    if_stage_if.master        imem,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       br_target,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              if_vld,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_vld_q, if_vld_d;

    logic        granted;
    logic        ld_if;
    logic [31:0] ld_pc;
    logic [31:0] ld_instr;
    logic [31:0] tgt_aligned;

    assign tgt_aligned = {br_target[31:2], 2'b00};
    assign granted     = imem.imem_req & imem.imem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ISSUE;
            fetch_pc_q   <= {RESET_PC[31:2], 2'b00};
            req_pc_q     <= '0;
            drop_q       <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= NOP_INSTR;
            if_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_vld_q     <= if_vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ld_if        = 1'b0;
        ld_pc        = req_pc_q;
        ld_instr     = imem.imem_rdata;

        case (state_q)
            S_ISSUE: begin
                if (granted) begin
                    state_d    = S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // A flush racing the grant turns the accepted fetch into wrong-path.
                    drop_d     = flush;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else if (flush) begin
                        state_d = S_ISSUE;
                    end else if (stall) begin
                        skid_pc_d    = req_pc_q;
                        skid_instr_d = imem.imem_rdata;
                        state_d      = S_FULL;
                    end else begin
                        ld_if = 1'b1;
                        if (granted) begin
                            req_pc_d   = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_d = S_ISSUE;
                end else if (!stall) begin
                    ld_if    = 1'b1;
                    ld_pc    = skid_pc_q;
                    ld_instr = skid_instr_q;
                    state_d  = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase

        if (flush) begin
            fetch_pc_d = tgt_aligned;
        end

        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_vld_d   = if_vld_q;
        if (flush) begin
            if_vld_d   = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (ld_if) begin
            if_pc_d    = ld_pc;
            if_instr_d = ld_instr;
            if_vld_d   = 1'b1;
        end else if (!stall) begin
            if_vld_d   = 1'b0;
            if_instr_d = NOP_INSTR;
        end
    end

    // Request is a function of state and same-cycle rvalid/stall/flush only, never of gnt.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = fetch_pc_q;
        if (!rst) begin
            case (state_q)
                S_ISSUE: imem.imem_req = 1'b1;
                S_WAIT:  imem.imem_req = imem.imem_rvalid & ~drop_q & ~flush & ~stall;
                default: imem.imem_req = 1'b0;
            endcase
        end
    end

    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_vld    = if_vld_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, reset-in-FULL sequence, then random
// memory/stall/flush traffic checked against a program-order stream model.
module tb_if_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          N_RAND    = 2000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] br_target;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_vld;
    logic [1:0]  state_dbg;

    if_stage_if mem ();

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (mem),
        .stall     (stall),
        .flush     (flush),
        .br_target (br_target),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_vld    (if_vld),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A0_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic g, input logic rv, input logic [31:0] rpc,
                       input logic st, input logic fl, input logic [31:0] tgt,
                       input logic req, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rpc = rpc; v.stall = st; v.flush = fl; v.tgt = tgt;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        vq.push_back(v);
    endtask

    // Random-phase memory model and stream reference
    logic [31:0] q_addr[$];
    int          q_rdy[$];
    logic [31:0] exp_pc;
    int          n_cons;

    initial begin
        logic        s_req, s_gnt, s_rv, s_stall, s_flush;
        logic [31:0] s_addr, s_tgt, s_pc, s_instr;
        logic        s_vld;
        logic        p_req, p_gnt, p_flush;
        logic [31:0] p_addr, p_tgt;
        int          cyc;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_target = '0;
        mem.imem_gnt = 1'b0; mem.imem_rvalid = 1'b0; mem.imem_rdata = '0;

        // gnt, rv, rpc, stall, flush, tgt | req, addr, vld, pc
        add(1,0,32'h0,  0,0,32'h0,        1,32'h0,        0,32'h0);
        add(1,1,32'h0,  0,0,32'h0,        1,32'h4,        1,32'h0);
        add(1,1,32'h4,  0,0,32'h0,        1,32'h8,        1,32'h4);
        add(0,1,32'h8,  0,0,32'h0,        1,32'hC,        1,32'h8);
        add(0,0,32'h0,  0,0,32'h0,        1,32'hC,        0,32'h8);
        add(0,0,32'h0,  0,0,32'h0,        1,32'hC,        0,32'h8);
        add(0,0,32'h0,  0,0,32'h0,        1,32'hC,        0,32'h8);
        add(1,0,32'h0,  0,0,32'h0,        1,32'hC,        0,32'h8);
        add(1,1,32'hC,  0,0,32'h0,        1,32'h10,       1,32'hC);
        add(1,1,32'h10, 1,0,32'h0,        0,32'h0,        1,32'hC);
        add(1,0,32'h0,  1,0,32'h0,        0,32'h0,        1,32'hC);
        add(1,0,32'h0,  1,0,32'h0,        0,32'h0,        1,32'hC);
        add(1,0,32'h0,  0,0,32'h0,        0,32'h0,        1,32'h10);
        add(1,0,32'h0,  0,0,32'h0,        1,32'h14,       0,32'h10);
        add(1,1,32'h14, 0,0,32'h0,        1,32'h18,       1,32'h14);
        add(1,0,32'h0,  0,1,32'h100,      0,32'h0,        0,32'h14);
        add(1,0,32'h0,  0,0,32'h0,        0,32'h0,        0,32'h14);
        add(1,1,32'h18, 0,0,32'h0,        0,32'h0,        0,32'h14);
        add(1,0,32'h0,  0,0,32'h0,        1,32'h100,      0,32'h14);
        add(1,1,32'h100,0,0,32'h0,        1,32'h104,      1,32'h100);
        add(1,1,32'h104,1,1,32'h203,      0,32'h0,        0,32'h100);
        add(1,0,32'h0,  0,1,32'h300,      1,32'h200,      0,32'h100);
        add(1,1,32'h200,0,0,32'h0,        0,32'h0,        0,32'h100);
        add(1,0,32'h0,  0,0,32'h0,        1,32'h300,      0,32'h100);
        add(0,1,32'h300,0,0,32'h0,        1,32'h304,      1,32'h300);
        add(0,0,32'h0,  1,0,32'h0,        1,32'h304,      1,32'h300);
        add(0,0,32'h0,  0,1,32'hFFFF_FFFC,1,32'h304,      0,32'h300);
        add(1,0,32'h0,  0,0,32'h0,        1,32'hFFFF_FFFC,0,32'h300);
        add(1,1,32'hFFFF_FFFC,0,0,32'h0,  1,32'h0,        1,32'hFFFF_FFFC);
        add(0,1,32'h0,  1,0,32'h0,        0,32'h0,        1,32'hFFFF_FFFC);

        // Reset: rvalid noise must be ignored and no request raised
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem.imem_rvalid = 1'b1; mem.imem_rdata = $urandom; mem.imem_gnt = 1'b1;
            #1 chk("rst_req", {31'd0, mem.imem_req}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_vld",   {31'd0, if_vld}, 32'd0);
        chk("rst_instr", if_instr, NOP_INSTR);
        chk("rst_pc",    if_pc, RESET_PC);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            mem.imem_gnt    = vq[i].gnt;
            mem.imem_rvalid = vq[i].rv;
            mem.imem_rdata  = ins(vq[i].rpc);
            stall           = vq[i].stall;
            flush           = vq[i].flush;
            br_target       = vq[i].tgt;
            #1;
            chk($sformatf("vec%0d_req", i), {31'd0, mem.imem_req}, {31'd0, vq[i].req});
            if (vq[i].req) chk($sformatf("vec%0d_addr", i), mem.imem_addr, vq[i].addr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_vld", i), {31'd0, if_vld}, {31'd0, vq[i].vld});
            chk($sformatf("vec%0d_pc", i), if_pc, vq[i].pc);
            chk($sformatf("vec%0d_instr", i), if_instr, vq[i].vld ? ins(vq[i].pc) : NOP_INSTR);
        end
        chk("full_state", {30'd0, state_dbg}, 32'd2);

        // Reset while holding a skid entry
        @(negedge clk);
        rst = 1'b1; stall = 1'b1; flush = 1'b0; mem.imem_gnt = 1'b1; mem.imem_rvalid = 1'b0;
        #1 chk("midrst_req", {31'd0, mem.imem_req}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_vld",   {31'd0, if_vld}, 32'd0);
        chk("midrst_instr", if_instr, NOP_INSTR);
        chk("midrst_pc",    if_pc, RESET_PC);
        chk("midrst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; mem.imem_gnt = 1'b0;
        #1;
        chk("post_rst_req",  {31'd0, mem.imem_req}, 32'd1);
        chk("post_rst_addr", mem.imem_addr, RESET_PC);
        @(posedge clk); #1;

        // Random traffic
        exp_pc = RESET_PC; n_cons = 0; cyc = 0;
        p_req = 1'b1; p_gnt = 1'b0; p_flush = 1'b0; p_addr = RESET_PC; p_tgt = '0;
        for (int n = 0; n < N_RAND; n++) begin
            @(negedge clk);
            cyc++;
            mem.imem_gnt = ($urandom_range(0, 9) < 7);
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            br_target    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            mem.imem_rvalid = (q_addr.size() > 0) && (q_rdy[0] <= cyc);
            mem.imem_rdata  = mem.imem_rvalid ? ins(q_addr[0]) : $urandom;
            #1;
            s_req = mem.imem_req; s_addr = mem.imem_addr; s_gnt = mem.imem_gnt;
            s_rv = mem.imem_rvalid; s_stall = stall; s_flush = flush;
            s_tgt = {br_target[31:2], 2'b00};
            s_vld = if_vld; s_pc = if_pc; s_instr = if_instr;

            if (s_req) chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
            if (p_req && !p_gnt) chk("req_held", {31'd0, s_req}, 32'd1);
            if (s_req && (p_flush || (p_req && !p_gnt)))
                chk("addr_stable", s_addr, p_flush ? p_tgt : p_addr);
            if (s_req && s_gnt)
                chk("one_outstanding", 32'(q_addr.size() - (s_rv ? 1 : 0)), 32'd0);
            if (!s_vld) chk("empty_nop", s_instr, NOP_INSTR);
            if (s_vld && !s_stall && !s_flush) begin
                chk("stream_pc", s_pc, exp_pc);
                chk("stream_instr", s_instr, ins(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end

            @(posedge clk); #1;
            if (s_flush) begin
                chk("flush_vld", {31'd0, if_vld}, 32'd0);
                chk("flush_instr", if_instr, NOP_INSTR);
                exp_pc = s_tgt;
            end else if (s_stall) begin
                chk("stall_vld", {31'd0, if_vld}, {31'd0, s_vld});
                chk("stall_pc", if_pc, s_pc);
                chk("stall_instr", if_instr, s_instr);
            end

            if (s_rv) begin
                void'(q_addr.pop_front());
                void'(q_rdy.pop_front());
            end
            if (s_req && s_gnt) begin
                q_addr.push_back(s_addr);
                q_rdy.push_back(cyc + 1 + int'($urandom_range(0, 2)));
            end
            p_req = s_req; p_gnt = s_gnt; p_flush = s_flush; p_addr = s_addr; p_tgt = s_tgt;
        end
        chk("progress", {31'd0, n_cons >= 150}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
